// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported data memory between instruction fetch and
//           the load/store stage; lane steering for stores, extension for loads.
// Latency : grant is combinational in the request cycle; read data, load
//           result and error flag appear exactly one cycle after the grant.
// Backpressure: a requester holds req until its gnt; data wins by default, but
//           fetch is forced through after STARVE_MAX consecutive denied cycles.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr            fetch request (word address, low bits ignored)
//   if_gnt/if_rvalid/if_rdata fetch accept, fetch response
//   dm_req/dm_we/dm_funct3    load/store request, RISC-V size/sign encoding
//   dm_addr/dm_wdata          byte address, right-aligned store data
//   dm_gnt/dm_rvalid/dm_rdata load/store accept, extended load result
//   dm_err                    one-cycle pulse for a misaligned/illegal access
//   mem_*                     single-port memory interface (1-cycle read)
module mem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // load/store stage
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_funct3,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              dm_err,
  // memory array
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // Kind of response owed in the cycle after a grant. Only one grant is
  // issued per cycle, so at most one response is ever outstanding.
  localparam logic [1:0] RSP_IDLE  = 2'd0;
  localparam logic [1:0] RSP_FETCH = 2'd1;
  localparam logic [1:0] RSP_LOAD  = 2'd2;
  localparam logic [1:0] RSP_ERR   = 2'd3;

  logic [CNT_W-1:0] starve_cnt;
  logic [1:0]       resp_q;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_off;
  logic [31:0]      if_rdata_q;
  logic [31:0]      dm_rdata_q;

  logic             dm_win;
  logic             if_win;
  logic [1:0]       dm_off;
  logic             dm_legal;
  logic             dm_access;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_ext;

  // Address bits above the array size wrap; fetch low bits are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], dm_addr[31:ADDR_W+2]};

  assign dm_off = dm_addr[1:0];

  // ---------------------------------------------------------------------------
  // Arbitration. Data has priority unless fetch has already been denied
  // STARVE_MAX cycles in a row. Grants are masked while reset is asserted so
  // every output reads 0 during reset.
  // ---------------------------------------------------------------------------
  assign dm_win = !rst && dm_req && ((starve_cnt < STARVE_LIM) || !if_req);
  assign if_win = !rst && if_req && !dm_win;
  assign dm_gnt = dm_win;
  assign if_gnt = if_win;

  // ---------------------------------------------------------------------------
  // Access legality. Illegal accesses are still granted (the requester must
  // not stall forever) but never touch the memory.
  // ---------------------------------------------------------------------------
  always_comb begin
    dm_legal = 1'b1;
    case (dm_funct3)
      3'b000, 3'b100: dm_legal = 1'b1;
      3'b001, 3'b101: dm_legal = ~dm_off[0];
      3'b010:         dm_legal = (dm_off == 2'b00);
      default:        dm_legal = 1'b0;
    endcase
    // Unsigned variants only exist for loads.
    if (dm_we && dm_funct3[2]) begin
      dm_legal = 1'b0;
    end
  end

  assign dm_access = dm_win && dm_legal;

  // ---------------------------------------------------------------------------
  // Store lane steering: data is replicated across all lanes so the byte
  // enables alone select the target bytes.
  // ---------------------------------------------------------------------------
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'h0000_0000;
    case (dm_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << dm_off;
        st_wdata = {4{dm_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = dm_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{dm_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = dm_wdata;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory port. Outputs are forced to 0 when no access is issued so the
  // array sees a quiet bus on idle and error cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = if_win || dm_access;
    mem_we    = dm_access && dm_we;
    mem_be    = mem_we ? st_be : 4'b0000;
    mem_wdata = mem_we ? st_wdata : 32'h0000_0000;
    if (dm_win) begin
      mem_addr = dm_addr[ADDR_W+1:2];
    end else if (if_win) begin
      mem_addr = if_addr[ADDR_W+1:2];
    end else begin
      mem_addr = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Load result: select the lane recorded at grant time from the word the
  // memory returns this cycle, then sign- or zero-extend.
  // ---------------------------------------------------------------------------
  always_comb begin
    ld_byte = mem_rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h00_0000, ld_byte};
      3'b101:  ld_ext = {16'h0000, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response outputs. Data buses follow the memory in a response cycle and
  // otherwise replay the last value; an error cycle presents 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    if_rvalid = !rst && (resp_q == RSP_FETCH);
    dm_rvalid = !rst && (resp_q == RSP_LOAD);
    dm_err    = !rst && (resp_q == RSP_ERR);

    if (rst) begin
      if_rdata = 32'h0000_0000;
    end else if (if_rvalid) begin
      if_rdata = mem_rdata;
    end else begin
      if_rdata = if_rdata_q;
    end

    if (rst || dm_err) begin
      dm_rdata = 32'h0000_0000;
    end else if (dm_rvalid) begin
      dm_rdata = ld_ext;
    end else begin
      dm_rdata = dm_rdata_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State: response pipeline, load lane info, starvation counter, held data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q     <= RSP_IDLE;
      ld_funct3  <= 3'b000;
      ld_off     <= 2'b00;
      starve_cnt <= '0;
      if_rdata_q <= 32'h0000_0000;
      dm_rdata_q <= 32'h0000_0000;
    end else begin
      if_rdata_q <= if_rdata;
      dm_rdata_q <= dm_rdata;

      if (if_win) begin
        resp_q <= RSP_FETCH;
      end else if (dm_win && !dm_legal) begin
        resp_q <= RSP_ERR;
      end else if (dm_access && !dm_we) begin
        resp_q <= RSP_LOAD;
      end else begin
        resp_q <= RSP_IDLE;
      end

      if (dm_access && !dm_we) begin
        ld_funct3 <= dm_funct3;
        ld_off    <= dm_off;
      end

      // Counts consecutive cycles a pending fetch was refused.
      if (!if_req || if_win) begin
        starve_cnt <= '0;
      end else if (starve_cnt < STARVE_LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 14;
  localparam int STARVE_MAX = 4;
  localparam int MEM_WORDS  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [2:0]        dm_funct3;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [31:0]       dm_rdata;
  logic              dm_err;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached memory array: registered read, byte-enabled write.
  logic [31:0] mem [MEM_WORDS];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // One record = one clock cycle of inputs and the outputs expected in it.
  // gnt = {if_gnt,dm_gnt}; mem = {mem_en,mem_we}; resp = {if_rvalid,dm_rvalid,dm_err};
  // erd = expected if_rdata/dm_rdata for whichever response is flagged.
  typedef struct {
    logic              rst;
    logic              ifr;
    logic [31:0]       ifa;
    logic              dmr;
    logic              we;
    logic [2:0]        f3;
    logic [31:0]       da;
    logic [31:0]       wd;
    logic [1:0]        gnt;
    logic [1:0]        mem;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       ewd;
    logic [2:0]        resp;
    logic [31:0]       erd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ifr, input logic [31:0] ifa,
                     input logic dmr, input logic we, input logic [2:0] f3,
                     input logic [31:0] da, input logic [31:0] wd,
                     input logic [1:0] gnt, input logic [1:0] mm, input logic [3:0] be,
                     input logic [ADDR_W-1:0] addr, input logic [31:0] ewd,
                     input logic [2:0] resp, input logic [31:0] erd);
    vec_t v;
    v.rst = r; v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.we = we; v.f3 = f3;
    v.da = da; v.wd = wd; v.gnt = gnt; v.mem = mm; v.be = be; v.addr = addr;
    v.ewd = ewd; v.resp = resp; v.erd = erd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic ifr, input logic [31:0] ifa,
                       input logic dmr, input logic we, input logic [2:0] f3,
                       input logic [31:0] da, input logic [31:0] wd);
    rst = r; if_req = ifr; if_addr = ifa; dm_req = dmr; dm_we = we;
    dm_funct3 = f3; dm_addr = da; dm_wdata = wd;
  endtask

  // Reference load result from the spec's lane/extension rules.
  function automatic logic [31:0] ld_model(input logic [31:0] word, input logic [2:0] f3, input int off);
    int size;
    logic [31:0] mask;
    logic [31:0] v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    v = word >> (8 * off);
    if (size < 4) begin
      mask = (32'h1 << (8 * size)) - 32'h1;
      v = v & mask;
      if (!f3[2] && v[8*size-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 7)) << 2);
    if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(0, 3));
    return a;
  endfunction

  logic [31:0] ref_mem [MEM_WORDS];

  initial begin
    int          if_wait, pend_kind, size, off, idx, nkind;
    logic [31:0] pend_data, ndata, e_wd;
    logic        hold_if, hold_dm, r_rst, e_ifg, e_dmg, e_en, e_we, legal;
    logic        cif_req, cdm_req, cdm_we;
    logic [31:0] cif_addr, cdm_addr, cdm_wd;
    logic [2:0]  cdm_f3;
    logic [3:0]  e_be;
    logic [ADDR_W-1:0] e_addr;

    //   rst ifr ifa          dmr we f3      da            wd            gnt    mem    be    addr     ewd           resp    erd
    add(1, 0, 32'h0,   0, 0, 3'b000, 32'h0,        32'h0,        2'b00, 2'b00, 4'h0, 14'h000, 32'h0,        3'b000, 32'h0);
    add(0, 0, 32'h0,   1, 1, 3'b010, 32'h100,      32'hDEADBEEF, 2'b01, 2'b11, 4'hF, 14'h040, 32'hDEADBEEF, 3'b000, 32'h0);
    add(0, 0, 32'h0,   1, 0, 3'b010, 32'h100,      32'h0,        2'b01, 2'b10, 4'h0, 14'h040, 32'h0,        3'b000, 32'h0);
    add(0, 0, 32'h0,   0, 0, 3'b000, 32'h0,        32'h0,        2'b00, 2'b00, 4'h0, 14'h000, 32'h0,        3'b010, 32'hDEADBEEF);
    add(0, 0, 32'h0,   1, 1, 3'b001, 32'h202,      32'h00008001, 2'b01, 2'b11, 4'hC, 14'h080, 32'h80018001, 3'b000, 32'h0);
    add(0, 0, 32'h0,   1, 0, 3'b001, 32'h202,      32'h0,        2'b01, 2'b10, 4'h0, 14'h080, 32'h0,        3'b000, 32'h0);
    add(0, 0, 32'h0,   1, 0, 3'b101, 32'h202,      32'h0,        2'b01, 2'b10, 4'h0, 14'h080, 32'h0,        3'b010, 32'hFFFF8001);
    add(0, 0, 32'h0,   1, 1, 3'b000, 32'h303,      32'h00000080, 2'b01, 2'b11, 4'h8, 14'h0C0, 32'h80808080, 3'b010, 32'h00008001);
    add(0, 0, 32'h0,   1, 0, 3'b000, 32'h303,      32'h0,        2'b01, 2'b10, 4'h0, 14'h0C0, 32'h0,        3'b000, 32'h0);
    add(0, 0, 32'h0,   1, 0, 3'b100, 32'h303,      32'h0,        2'b01, 2'b10, 4'h0, 14'h0C0, 32'h0,        3'b010, 32'hFFFFFF80);
    add(0, 0, 32'h0,   1, 0, 3'b010, 32'h300,      32'h0,        2'b01, 2'b10, 4'h0, 14'h0C0, 32'h0,        3'b010, 32'h00000080);
    add(0, 0, 32'h0,   0, 0, 3'b000, 32'h0,        32'h0,        2'b00, 2'b00, 4'h0, 14'h000, 32'h0,        3'b010, 32'h80000000);
    // illegal accesses: granted, no memory access, error pulse next cycle
    add(0, 0, 32'h0,   1, 0, 3'b010, 32'h101,      32'h0,        2'b01, 2'b00, 4'h0, 14'h000, 32'h0,        3'b000, 32'h0);
    add(0, 0, 32'h0,   1, 1, 3'b001, 32'h203,      32'h00001234, 2'b01, 2'b00, 4'h0, 14'h000, 32'h0,        3'b001, 32'h0);
    add(0, 0, 32'h0,   1, 0, 3'b011, 32'h100,      32'h0,        2'b01, 2'b00, 4'h0, 14'h000, 32'h0,        3'b001, 32'h0);
    add(0, 0, 32'h0,   0, 0, 3'b000, 32'h0,        32'h0,        2'b00, 2'b00, 4'h0, 14'h000, 32'h0,        3'b001, 32'h0);
    add(0, 0, 32'h0,   0, 0, 3'b000, 32'h0,        32'h0,        2'b00, 2'b00, 4'h0, 14'h000, 32'h0,        3'b000, 32'h0);
    add(0, 0, 32'h0,   1, 0, 3'b010, 32'h100,      32'h0,        2'b01, 2'b10, 4'h0, 14'h040, 32'h0,        3'b000, 32'h0);
    add(0, 0, 32'h0,   1, 0, 3'b010, 32'h200,      32'h0,        2'b01, 2'b10, 4'h0, 14'h080, 32'h0,        3'b010, 32'hDEADBEEF);
    add(0, 0, 32'h0,   0, 0, 3'b000, 32'h0,        32'h0,        2'b00, 2'b00, 4'h0, 14'h000, 32'h0,        3'b010, 32'h80010000);
    add(0, 0, 32'h0,   1, 1, 3'b100, 32'h0,        32'hFFFFFFFF, 2'b01, 2'b00, 4'h0, 14'h000, 32'h0,        3'b000, 32'h0);
    add(0, 0, 32'h0,   0, 0, 3'b000, 32'h0,        32'h0,        2'b00, 2'b00, 4'h0, 14'h000, 32'h0,        3'b001, 32'h0);
    // fetch ignores low address bits
    add(0, 1, 32'h102, 0, 0, 3'b000, 32'h0,        32'h0,        2'b10, 2'b10, 4'h0, 14'h040, 32'h0,        3'b000, 32'h0);
    add(0, 0, 32'h0,   0, 0, 3'b000, 32'h0,        32'h0,        2'b00, 2'b00, 4'h0, 14'h000, 32'h0,        3'b100, 32'hDEADBEEF);
    // back-to-back store then load, and address wrap
    add(0, 0, 32'h0,   1, 1, 3'b010, 32'h400,      32'h12345678, 2'b01, 2'b11, 4'hF, 14'h100, 32'h12345678, 3'b000, 32'h0);
    add(0, 0, 32'h0,   1, 0, 3'b010, 32'h400,      32'h0,        2'b01, 2'b10, 4'h0, 14'h100, 32'h0,        3'b000, 32'h0);
    add(0, 0, 32'h0,   0, 0, 3'b000, 32'h0,        32'h0,        2'b00, 2'b00, 4'h0, 14'h000, 32'h0,        3'b010, 32'h12345678);
    add(0, 0, 32'h0,   1, 1, 3'b010, 32'hFFFF0400, 32'hCAFEF00D, 2'b01, 2'b11, 4'hF, 14'h100, 32'hCAFEF00D, 3'b000, 32'h0);
    add(0, 0, 32'h0,   1, 0, 3'b010, 32'h400,      32'h0,        2'b01, 2'b10, 4'h0, 14'h100, 32'h0,        3'b000, 32'h0);
    add(0, 0, 32'h0,   0, 0, 3'b000, 32'h0,        32'h0,        2'b00, 2'b00, 4'h0, 14'h000, 32'h0,        3'b010, 32'hCAFEF00D);
    // reset the cycle after a load grant drops the response
    add(0, 0, 32'h0,   1, 1, 3'b010, 32'h0,        32'h0BADF00D, 2'b01, 2'b11, 4'hF, 14'h000, 32'h0BADF00D, 3'b000, 32'h0);
    add(0, 0, 32'h0,   1, 0, 3'b010, 32'h400,      32'h0,        2'b01, 2'b10, 4'h0, 14'h100, 32'h0,        3'b000, 32'h0);
    add(1, 1, 32'h0,   1, 0, 3'b010, 32'h400,      32'h0,        2'b00, 2'b00, 4'h0, 14'h000, 32'h0,        3'b000, 32'h0);
    add(0, 0, 32'h0,   0, 0, 3'b000, 32'h0,        32'h0,        2'b00, 2'b00, 4'h0, 14'h000, 32'h0,        3'b000, 32'h0);
    add(0, 1, 32'h0,   0, 0, 3'b000, 32'h0,        32'h0,        2'b10, 2'b10, 4'h0, 14'h000, 32'h0,        3'b000, 32'h0);
    add(0, 0, 32'h0,   0, 0, 3'b000, 32'h0,        32'h0,        2'b00, 2'b00, 4'h0, 14'h000, 32'h0,        3'b100, 32'h0BADF00D);
    // both requesting: four data grants, one forced fetch, data resumes
    add(0, 1, 32'h0,   1, 0, 3'b010, 32'h400,      32'h0,        2'b01, 2'b10, 4'h0, 14'h100, 32'h0,        3'b000, 32'h0);
    add(0, 1, 32'h0,   1, 0, 3'b010, 32'h400,      32'h0,        2'b01, 2'b10, 4'h0, 14'h100, 32'h0,        3'b010, 32'hCAFEF00D);
    add(0, 1, 32'h0,   1, 0, 3'b010, 32'h400,      32'h0,        2'b01, 2'b10, 4'h0, 14'h100, 32'h0,        3'b010, 32'hCAFEF00D);
    add(0, 1, 32'h0,   1, 0, 3'b010, 32'h400,      32'h0,        2'b01, 2'b10, 4'h0, 14'h100, 32'h0,        3'b010, 32'hCAFEF00D);
    add(0, 1, 32'h0,   1, 0, 3'b010, 32'h400,      32'h0,        2'b10, 2'b10, 4'h0, 14'h000, 32'h0,        3'b010, 32'hCAFEF00D);
    add(0, 1, 32'h0,   1, 0, 3'b010, 32'h400,      32'h0,        2'b01, 2'b10, 4'h0, 14'h100, 32'h0,        3'b100, 32'h0BADF00D);
    add(0, 0, 32'h0,   0, 0, 3'b000, 32'h0,        32'h0,        2'b00, 2'b00, 4'h0, 14'h000, 32'h0,        3'b010, 32'hCAFEF00D);

    mem_clr = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    mem_clr = 1'b0;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      @(posedge clk); #1;
      drive(v.rst, v.ifr, v.ifa, v.dmr, v.we, v.f3, v.da, v.wd);
      #3;
      chk($sformatf("v%0d_gnt", i), 32'({if_gnt, dm_gnt}), 32'(v.gnt));
      chk($sformatf("v%0d_mem", i), 32'({mem_en, mem_we}), 32'(v.mem));
      chk($sformatf("v%0d_be", i), 32'(mem_be), 32'(v.be));
      if (v.mem[1]) chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(v.addr));
      if (v.mem[0]) chk($sformatf("v%0d_wdata", i), mem_wdata, v.ewd);
      chk($sformatf("v%0d_resp", i), 32'({if_rvalid, dm_rvalid, dm_err}), 32'(v.resp));
      if (v.resp[2]) chk($sformatf("v%0d_if_rdata", i), if_rdata, v.erd);
      if (v.resp[1]) chk($sformatf("v%0d_dm_rdata", i), dm_rdata, v.erd);
      if (v.resp[0]) chk($sformatf("v%0d_err_rdata", i), dm_rdata, 32'h0);
      if (v.rst) begin
        chk($sformatf("v%0d_rst_rdata", i), if_rdata | dm_rdata, 32'h0);
        chk($sformatf("v%0d_rst_bus", i), 32'(mem_addr) | mem_wdata, 32'h0);
      end
    end

    // ---- randomized phase against the reference model ----
    @(posedge clk); #1;
    mem_clr = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'h0;
    if_wait = 0; pend_kind = 0; pend_data = 32'h0;
    hold_if = 1'b0; hold_dm = 1'b0;
    cif_req = 1'b0; cif_addr = 32'h0; cdm_req = 1'b0; cdm_we = 1'b0;
    cdm_f3 = 3'b000; cdm_addr = 32'h0; cdm_wd = 32'h0;

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      mem_clr = 1'b0;
      r_rst = (n > 0) && ($urandom_range(0, 63) == 0);
      if (!hold_if) begin
        cif_req  = ($urandom_range(0, 2) != 0);
        cif_addr = rand_addr();
      end
      if (!hold_dm) begin
        cdm_req  = ($urandom_range(0, 2) != 0);
        cdm_we   = ($urandom_range(0, 1) == 1);
        cdm_f3   = 3'($urandom_range(0, 7));
        cdm_addr = rand_addr();
        cdm_wd   = $urandom;
      end
      drive(r_rst, cif_req, cif_addr, cdm_req, cdm_we, cdm_f3, cdm_addr, cdm_wd);

      size  = (cdm_f3[1:0] == 2'b00) ? 1 : (cdm_f3[1:0] == 2'b01) ? 2 : 4;
      off   = int'(cdm_addr[1:0]);
      legal = (cdm_f3[1:0] != 2'b11) && !(cdm_f3[2] && (cdm_f3[1] || cdm_we)) && ((off % size) == 0);
      if (r_rst) begin
        e_dmg = 1'b0;
        e_ifg = 1'b0;
      end else begin
        e_dmg = cdm_req && ((if_wait < STARVE_MAX) || !cif_req);
        e_ifg = cif_req && !e_dmg;
      end
      e_en   = e_ifg || (e_dmg && legal);
      e_we   = e_dmg && legal && cdm_we;
      e_be   = e_we ? 4'(((1 << size) - 1) << off) : 4'h0;
      e_wd   = (size == 1) ? (cdm_wd & 32'hFF) * 32'h01010101 :
               (size == 2) ? (cdm_wd & 32'hFFFF) * 32'h00010001 : cdm_wd;
      e_addr = e_dmg ? ADDR_W'((cdm_addr >> 2) % MEM_WORDS) : ADDR_W'((cif_addr >> 2) % MEM_WORDS);
      #3;

      chk("rnd_gnt", 32'({if_gnt, dm_gnt}), 32'({e_ifg, e_dmg}));
      chk("rnd_mem", 32'({mem_en, mem_we}), 32'({e_en, e_we}));
      chk("rnd_be", 32'(mem_be), 32'(e_be));
      if (e_en) chk("rnd_addr", 32'(mem_addr), 32'(e_addr));
      if (e_we) chk("rnd_wdata", mem_wdata, e_wd);
      if (r_rst) begin
        chk("rnd_rst_resp", 32'({if_rvalid, dm_rvalid, dm_err}), 32'h0);
      end else begin
        chk("rnd_resp", 32'({if_rvalid, dm_rvalid, dm_err}),
            32'({pend_kind == 1, pend_kind == 2, pend_kind == 3}));
        if (pend_kind == 1) chk("rnd_if_rdata", if_rdata, pend_data);
        if (pend_kind == 2) chk("rnd_dm_rdata", dm_rdata, pend_data);
        if (pend_kind == 3) chk("rnd_err_rdata", dm_rdata, 32'h0);
      end

      // advance the model past the clock edge
      nkind = 0;
      ndata = 32'h0;
      if (e_ifg) begin
        nkind = 1;
        ndata = ref_mem[(cif_addr >> 2) % MEM_WORDS];
      end else if (e_dmg && !legal) begin
        nkind = 3;
      end else if (e_dmg && !cdm_we) begin
        nkind = 2;
        ndata = ld_model(ref_mem[(cdm_addr >> 2) % MEM_WORDS], cdm_f3, off);
      end else if (e_we) begin
        idx = int'((cdm_addr >> 2) % MEM_WORDS);
        for (int k = 0; k < size; k++) begin
          ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * (off + k))))
                       | (((cdm_wd >> (8 * k)) & 32'hFF) << (8 * (off + k)));
        end
      end
      pend_kind = r_rst ? 0 : nkind;
      pend_data = ndata;
      if (r_rst || !cif_req || e_ifg) if_wait = 0;
      else if (if_wait < STARVE_MAX) if_wait = if_wait + 1;
      hold_if = cif_req && !e_ifg && !r_rst;
      hold_dm = cdm_req && !e_dmg && !r_rst;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
